// File: rtl/cpu7_ifu_ibuf_pkg.sv
// Shared widths and entry layout for the cpu7 front-end instruction buffer.
package cpu7_ifu_ibuf_pkg;

    localparam int GRLEN     = 32;
    localparam int LANES     = 4;
    localparam int PC_W      = GRLEN;
    localparam int INST_W    = 32;
    localparam int EX_W      = 1;
    localparam int EXCCODE_W = 6;
    localparam int ENTRY_W   = PC_W + INST_W + EX_W + EXCCODE_W;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [INST_W-1:0]    inst;
        logic                 ex;
        logic [EXCCODE_W-1:0] exccode;
    } ibuf_entry_t;

    // An exception group always occupies exactly one entry regardless of lane count.
    function automatic logic [2:0] group_len(input logic ex, input logic [1:0] lanes_m1);
        return ex ? 3'd1 : ({1'b0, lanes_m1} + 3'd1);
    endfunction

endpackage

// File: rtl/cpu7_ifu_ibuf_wsel.sv
// Maps a fetch group onto per-entry write enables and entry data starting at tail.
module cpu7_ifu_ibuf_wsel
    import cpu7_ifu_ibuf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [$clog2(DEPTH)-1:0]  tail,
    input  logic [GRLEN-1:0]          fg_pc,
    input  logic [1:0]                fg_count,
    input  logic [127:0]              fg_rdata,
    input  logic                      fg_ex,
    input  logic [5:0]                fg_exccode,
    output logic [DEPTH-1:0]          we,
    output logic [DEPTH*ENTRY_W-1:0]  wdata
);

    localparam int PTR_W = $clog2(DEPTH);

    ibuf_entry_t      ent;
    logic [PTR_W-1:0] widx;

    always_comb begin
        we    = '0;
        wdata = '0;
        ent   = '0;
        widx  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l == 0 || (!fg_ex && l <= int'(fg_count))) begin
                widx        = tail + PTR_W'(l);
                ent.pc      = fg_pc + GRLEN'(4 * l);
                ent.inst    = fg_ex ? '0 : fg_rdata[32*l +: 32];
                ent.ex      = fg_ex;
                ent.exccode = fg_ex ? fg_exccode : '0;
                we[widx]    = 1'b1;
                wdata[widx*ENTRY_W +: ENTRY_W] = ent;
            end
        end
    end

endmodule

// File: rtl/cpu7_ifu_ibuf.sv
// Circular instruction buffer: up to 4 instructions in per cycle, one out to decode.
module cpu7_ifu_ibuf
    import cpu7_ifu_ibuf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fg_valid,
    output logic                     fg_ready,
    input  logic [GRLEN-1:0]         fg_pc,
    input  logic [1:0]               fg_count,
    input  logic [127:0]             fg_rdata,
    input  logic                     fg_ex,
    input  logic [5:0]               fg_exccode,
    input  logic                     br_cancel,
    input  logic                     de_allow_in,
    output logic                     o_port0_valid,
    output logic [GRLEN-1:0]         o_port0_pc,
    output logic [31:0]              o_port0_inst,
    output logic                     o_port0_ex,
    output logic [5:0]               o_port0_exccode,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [CNT_W-1:0]         count;
    logic [ENTRY_W-1:0]       storage [DEPTH];
    logic                     push;
    logic                     pop;
    logic [2:0]               push_len;
    logic [DEPTH-1:0]         we;
    logic [DEPTH*ENTRY_W-1:0] wdata;
    ibuf_entry_t              head_e;

    cpu7_ifu_ibuf_wsel #(.DEPTH(DEPTH)) u_wsel (
        .tail       (tail),
        .fg_pc      (fg_pc),
        .fg_count   (fg_count),
        .fg_rdata   (fg_rdata),
        .fg_ex      (fg_ex),
        .fg_exccode (fg_exccode),
        .we         (we),
        .wdata      (wdata)
    );

    // Ready only looks at the registered count so fetch sees a stable signal.
    assign fg_ready = (count <= CNT_W'(DEPTH - 4));
    assign push     = fg_valid && fg_ready && !br_cancel;
    assign pop      = o_port0_valid && de_allow_in;
    assign push_len = group_len(fg_ex, fg_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (br_cancel) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                if (push) begin
                    tail <= tail + PTR_W'(push_len);
                end
                count <= count + (push ? CNT_W'(push_len) : '0) - CNT_W'(pop);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && we[i]) begin
                    storage[i] <= wdata[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    assign head_e          = storage[head];
    assign o_port0_valid   = (count != '0);
    assign o_port0_pc      = head_e.pc;
    assign o_port0_inst    = head_e.inst;
    assign o_port0_ex      = head_e.ex;
    assign o_port0_exccode = head_e.exccode;
    assign o_count         = count;

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Directed bench for cpu7_ifu_ibuf: vector table plus full, wrap and async-reset sequences.
module tb_cpu7_ifu_ibuf;

    logic         clk;
    logic         rst;
    logic         fg_valid;
    logic         fg_ready;
    logic [31:0]  fg_pc;
    logic [1:0]   fg_count;
    logic [127:0] fg_rdata;
    logic         fg_ex;
    logic [5:0]   fg_exccode;
    logic         br_cancel;
    logic         de_allow_in;
    logic         o_port0_valid;
    logic [31:0]  o_port0_pc;
    logic [31:0]  o_port0_inst;
    logic         o_port0_ex;
    logic [5:0]   o_port0_exccode;
    logic [3:0]   o_count;

    int n_tests = 0;
    int n_fail  = 0;

    cpu7_ifu_ibuf #(.DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .fg_valid        (fg_valid),
        .fg_ready        (fg_ready),
        .fg_pc           (fg_pc),
        .fg_count        (fg_count),
        .fg_rdata        (fg_rdata),
        .fg_ex           (fg_ex),
        .fg_exccode      (fg_exccode),
        .br_cancel       (br_cancel),
        .de_allow_in     (de_allow_in),
        .o_port0_valid   (o_port0_valid),
        .o_port0_pc      (o_port0_pc),
        .o_port0_inst    (o_port0_inst),
        .o_port0_ex      (o_port0_ex),
        .o_port0_exccode (o_port0_exccode),
        .o_count         (o_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         v;
        logic [31:0]  pc;
        logic [1:0]   cnt;
        logic [127:0] rd;
        logic         ex;
        logic [5:0]   code;
        logic         bc;
        logic         al;
        logic         e_v;
        logic [31:0]  e_pc;
        logic [31:0]  e_inst;
        logic         e_ex;
        logic [5:0]   e_code;
        logic [3:0]   e_cnt;
        logic         e_rdy;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [127:0] ln(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [1:0] cnt,
                                input logic [127:0] rd, input logic ex, input logic [5:0] code,
                                input logic bc, input logic al, input logic e_v,
                                input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic e_ex, input logic [5:0] e_code,
                                input logic [3:0] e_cnt, input logic e_rdy);
        vec_t r;
        r.v = v; r.pc = pc; r.cnt = cnt; r.rd = rd; r.ex = ex; r.code = code;
        r.bc = bc; r.al = al; r.e_v = e_v; r.e_pc = e_pc; r.e_inst = e_inst;
        r.e_ex = e_ex; r.e_code = e_code; r.e_cnt = e_cnt; r.e_rdy = e_rdy;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle(input logic al);
        fg_valid    = 1'b0;
        fg_pc       = '0;
        fg_count    = '0;
        fg_rdata    = '0;
        fg_ex       = 1'b0;
        fg_exccode  = '0;
        br_cancel   = 1'b0;
        de_allow_in = al;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] WBASE = 32'h1c003000;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          g;
        int          m_cnt;
        int          n_out;
        int          cyc;
        logic        acc;
        logic        popm;
        logic [31:0] exp_pc;

        vecs[0]  = mk(1, 32'h1c000000, 3, ln('hA0, 'hA1, 'hA2, 'hA3), 0, 0, 0, 1,  1, 32'h1c000000, 'hA0, 0, 0, 4, 1);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       1, 32'h1c000004, 'hA1, 0, 0, 3, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       1, 32'h1c000008, 'hA2, 0, 0, 2, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       1, 32'h1c00000c, 'hA3, 0, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       0, 0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(1, 32'h1c000100, 3, ln('hDEADBEE0, 'hDEADBEE1, 'hDEADBEE2, 'hDEADBEE3), 1, 6'h08, 0, 0,
                                                                                    1, 32'h1c000100, 0, 1, 6'h08, 1, 1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       0, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(1, 32'h1c000200, 3, ln('hB0, 'hB1, 'hB2, 'hB3), 0, 0, 0, 0,  1, 32'h1c000200, 'hB0, 0, 0, 4, 1);
        vecs[8]  = mk(1, 32'h1c000210, 0, ln('hC0, 0, 0, 0), 0, 0, 0, 0,           1, 32'h1c000200, 'hB0, 0, 0, 5, 0);
        vecs[9]  = mk(1, 32'h1c000300, 3, ln('hE0, 'hE1, 'hE2, 'hE3), 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,                                       0, 0, 0, 0, 0, 0, 1);
        vecs[11] = mk(1, 32'h1c000400, 1, ln('hD0, 'hD1, 0, 0), 0, 0, 0, 0,        1, 32'h1c000400, 'hD0, 0, 0, 2, 1);
        vecs[12] = mk(1, 32'h1c000500, 0, ln('hEE, 0, 0, 0), 0, 0, 1, 1,           0, 0, 0, 0, 0, 0, 1);
        vecs[13] = mk(1, 32'h1c000600, 0, ln('hF0, 0, 0, 0), 0, 0, 0, 0,           1, 32'h1c000600, 'hF0, 0, 0, 1, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       0, 0, 0, 0, 0, 0, 1);
        vecs[15] = mk(1, 32'h1c000700, 1, ln('h70, 'h71, 0, 0), 0, 0, 0, 1,        1, 32'h1c000700, 'h70, 0, 0, 2, 1);
        vecs[16] = mk(1, 32'h1c000800, 0, ln('h80, 0, 0, 0), 0, 0, 0, 1,           1, 32'h1c000704, 'h71, 0, 0, 2, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       1, 32'h1c000800, 'h80, 0, 0, 1, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 1,                                       0, 0, 0, 0, 0, 0, 1);

        // Reset state
        rst = 1'b1;
        drive_idle(1'b0);
        #12;
        check("rst_valid", 64'(o_port0_valid), 0);
        check("rst_count", 64'(o_count), 0);
        check("rst_ready", 64'(fg_ready), 1);
        check("rst_pc",    64'(o_port0_pc), 0);
        check("rst_inst",  64'(o_port0_inst), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Vector table
        for (int i = 0; i < 19; i++) begin
            fg_valid    = vecs[i].v;
            fg_pc       = vecs[i].pc;
            fg_count    = vecs[i].cnt;
            fg_rdata    = vecs[i].rd;
            fg_ex       = vecs[i].ex;
            fg_exccode  = vecs[i].code;
            br_cancel   = vecs[i].bc;
            de_allow_in = vecs[i].al;
            step();
            check($sformatf("v%0d_valid", i), 64'(o_port0_valid), 64'(vecs[i].e_v));
            check($sformatf("v%0d_count", i), 64'(o_count), 64'(vecs[i].e_cnt));
            check($sformatf("v%0d_ready", i), 64'(fg_ready), 64'(vecs[i].e_rdy));
            if (vecs[i].e_v) begin
                check($sformatf("v%0d_pc", i),   64'(o_port0_pc), 64'(vecs[i].e_pc));
                check($sformatf("v%0d_inst", i), 64'(o_port0_inst), 64'(vecs[i].e_inst));
                check($sformatf("v%0d_ex", i),   64'(o_port0_ex), 64'(vecs[i].e_ex));
                check($sformatf("v%0d_code", i), 64'(o_port0_exccode), 64'(vecs[i].e_code));
            end
        end

        // Fill to DEPTH, ignored third group, then drain in order
        drive_idle(1'b0);
        fg_valid = 1'b1; fg_pc = 32'h1c001000; fg_count = 3;
        fg_rdata = ln('h100, 'h101, 'h102, 'h103);
        step();
        check("full_cnt4", 64'(o_count), 4);
        check("full_rdy4", 64'(fg_ready), 1);
        fg_pc = 32'h1c001010;
        fg_rdata = ln('h104, 'h105, 'h106, 'h107);
        step();
        check("full_cnt8", 64'(o_count), 8);
        check("full_rdy8", 64'(fg_ready), 0);
        check("full_valid", 64'(o_port0_valid), 1);
        fg_pc = 32'h1c002000;
        fg_rdata = ln('h200, 'h201, 'h202, 'h203);
        step();
        check("full_ignored_cnt", 64'(o_count), 8);
        check("full_ignored_pc", 64'(o_port0_pc), 64'h1c001000);
        drive_idle(1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_pc", i),   64'(o_port0_pc), 64'(32'h1c001000 + 32'(4 * i)));
            check($sformatf("drain%0d_inst", i), 64'(o_port0_inst), 64'('h100 + i));
            check($sformatf("drain%0d_cnt", i),  64'(o_count), 64'(8 - i));
            check($sformatf("drain%0d_rdy", i),  64'(fg_ready), 64'((8 - i) <= 4));
            step();
        end
        check("drain_empty", 64'(o_port0_valid), 0);

        // Wrap-around: 20 three-lane groups against one pop per cycle
        g = 0; m_cnt = 0; n_out = 0; cyc = 0; exp_pc = WBASE;
        while (n_out < 60 && cyc < 300) begin
            check("wrap_count", 64'(o_count), 64'(m_cnt));
            check("wrap_ready", 64'(fg_ready), 64'(m_cnt <= 4));
            check("wrap_limit", 64'(o_count <= 4'd8), 1);
            if (m_cnt != 0) begin
                check("wrap_valid", 64'(o_port0_valid), 1);
                check("wrap_pc",    64'(o_port0_pc), 64'(exp_pc));
                check("wrap_inst",  64'(o_port0_inst), 64'(32'h300 + ((exp_pc - WBASE) >> 2)));
            end
            drive_idle(1'b1);
            fg_valid = (g < 20);
            fg_pc    = WBASE + 32'(12 * g);
            fg_count = 2;
            fg_rdata = ln(32'(32'h300 + 3 * g), 32'(32'h301 + 3 * g), 32'(32'h302 + 3 * g), 32'hBAD0BAD0);
            acc  = (g < 20) && (m_cnt <= 4);
            popm = (m_cnt != 0);
            step();
            if (popm) begin
                exp_pc = exp_pc + 4;
                n_out++;
            end
            if (acc) g++;
            m_cnt = m_cnt + (acc ? 3 : 0) - (popm ? 1 : 0);
            cyc++;
        end
        check("wrap_n_out", 64'(n_out), 60);
        check("wrap_final_cnt", 64'(o_count), 0);

        // Asynchronous reset in mid-cycle
        drive_idle(1'b0);
        fg_valid = 1'b1; fg_pc = 32'h1c005000; fg_count = 3; fg_ex = 1'b1; fg_exccode = 6'h1f;
        step();
        check("ar_pre_valid", 64'(o_port0_valid), 1);
        check("ar_pre_code",  64'(o_port0_exccode), 64'h1f);
        drive_idle(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(o_port0_valid), 0);
        check("ar_pc",    64'(o_port0_pc), 0);
        check("ar_inst",  64'(o_port0_inst), 0);
        check("ar_ex",    64'(o_port0_ex), 0);
        check("ar_code",  64'(o_port0_exccode), 0);
        check("ar_count", 64'(o_count), 0);
        check("ar_ready", 64'(fg_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("ar_post_count", 64'(o_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu7_ifu_ibuf.md
# cpu7_ifu_ibuf

Instruction buffer between the fetch data path and the decoder in the cpu7 front end. It accepts 128-bit fetch groups of 1–4 instructions and holds them in a circular queue. It delivers one instruction per cycle to the decode stage under a valid/allow-in handshake. It decouples fetch-bus bursts from decode stalls and drops all buffered instructions on a branch cancel from the execute unit.

## Interface
- DEPTH, 8, entry count; power of two, ≥4
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- fg_valid  in  1  fetch group present this cycle
- fg_ready  out  1  buffer can accept a full group (free entries ≥4)
- fg_pc  in  `GRLEN  pc of lane 0; word-aligned
- fg_count  in  2  number of valid lanes minus 1 (0→1 inst … 3→4 insts)
- fg_rdata  in  128  lane i = fg_rdata[32i+31:32i], pc = fg_pc+4i
- fg_ex  in  1  fetch exception on this group
- fg_exccode  in  6  exception code
- br_cancel  in  1  flush (exu_ifu_br_cancel)
- de_allow_in  in  1  decoder accepts head entry this cycle
- o_port0_valid  out  1  head entry valid
- o_port0_pc  out  `GRLEN  head pc
- o_port0_inst  out  32  head instruction word
- o_port0_ex  out  1  head carries fetch exception
- o_port0_exccode  out  6  head exception code
- o_count  out  log2(DEPTH)+1  occupied entries (debug/perf)

## Operation
- Storage: DEPTH entries of {pc, inst, ex, exccode}; head pointer, tail pointer and count, all log2(DEPTH) bits except count (log2(DEPTH)+1); pointers wrap modulo DEPTH.
- Push: fg_valid && fg_ready. Normal group writes lanes 0..fg_count to entries tail..tail+fg_count; tail += fg_count+1.
- Exception group (fg_ex=1): writes exactly one entry {pc=fg_pc, inst=32'h0, ex=1, exccode=fg_exccode}; fg_count and fg_rdata are ignored; tail += 1.
- Pop: o_port0_valid && de_allow_in; head += 1.
- Simultaneous push and pop: count_next = count + pushed − popped.
- fg_ready = (DEPTH − count) ≥ 4. It is computed from the registered count only and does not credit a same-cycle pop.
- o_port0_valid = (count != 0). o_port0_* are driven from storage[head], a registered value with no bypass from fg_*.
- br_cancel: head, tail and count return to 0 next cycle. A push in the same cycle is discarded; a same-cycle pop is still considered consumed by the decoder.
- fg_valid while fg_ready=0: the group is ignored with no state change; fetch must hold it.
- Entry contents are not cleared on pop or flush; only pointers and count are cleared.

## Timing
- Reset (async assert): head=tail=count=0; all entries zeroed; o_port0_valid=0, o_port0_pc=0, o_port0_inst=0, o_port0_ex=0, o_port0_exccode=0, o_count=0, fg_ready=1.
- Push-to-output latency: 1 cycle. A group accepted in cycle N presents lane 0 on o_port0_* in cycle N+1 if the buffer was empty.
- Throughput: 1 instruction/cycle out; up to 4/cycle in.
- Flush: o_port0_valid=0 in the cycle after br_cancel. A push is accepted again that same next cycle.
- Full: count=DEPTH → fg_ready=0 and o_port0_valid=1. count = DEPTH−3..DEPTH−1 also gives fg_ready=0.

## Structure
- `GRLEN comes from common.vh.
- Add to common.vh: IBUF entry field widths and an ENTRY_W constant (GRLEN+32+1+6).
- Natural sub-module: cpu7_ifu_ibuf_wsel. It is combinational; it maps the 4 lanes plus the exception flag to per-entry write enables and data given tail.
- The pointer/count register logic lives in the top module.

## Test plan
- Empty buffer, push {pc=0x1c000000, count=3, rdata=lanes 0xA0,0xA1,0xA2,0xA3}, de_allow_in=1 → o_port0_valid from cycle N+1; pcs 0x1c000000..0x1c00000c with insts 0xA0..0xA3 on consecutive cycles; then valid=0.
- de_allow_in=0, push two 4-lane groups (DEPTH=8) → count=8, fg_ready=0; a third fg_valid is ignored; release de_allow_in → first 8 insts emerge in order and fg_ready returns when count≤4.
- Push with fg_ex=1, exccode=6'h08, count=3 → exactly one entry, o_port0_ex=1, exccode=0x08, inst=0, count=1.
- Buffer holding 5 entries, br_cancel asserted together with fg_valid → next cycle count=0, o_port0_valid=0; the concurrent group is not visible.
- Wrap-around: repeated 3-lane pushes with steady pops over 20 groups → pc sequence contiguous, no loss or duplication, count never exceeds 8.
- Reset asserted mid-stream asynchronously → all outputs 0 and fg_ready=1 before the next clock edge.
